context_switcher: RTL and testbench
===================================

// Module: context_switcher
// PURPOSE
//  Consumes the scheduler's troca_contexto pulse and processo_atual PID. Performs the context switch on the CPU.
//  Sequence: stall the CPU, save the outgoing process's PC and NREG registers into an internal context table,
//  restore the incoming process's context, reload the PC. Sits between the scheduler and the CPU core / register file.
// PARAMETERS
//  NPROC     10          number of context table entries (valid PIDs 0..NPROC-1)
//  NREG      8           registers saved/restored per process (rf addresses 0..NREG-1)
//  PROC_SIZE 32'd1024    per-process memory stride; base = pid*PROC_SIZE; also the initial PC of a fresh process
// PORTS
//  clock          in   1   system clock, rising edge
//  reset          in   1   asynchronous, active-high
//  troca_contexto in   1   switch request pulse from scheduler
//  processo_atual in   32  PID to switch to (valid while troca_contexto=1)
//  cpu_halted     in   1   CPU acknowledges stall; pipeline drained
//  cpu_pc         in   32  CPU's current PC (valid while cpu_halted=1)
//  rf_rdata       in   32  register file read data (combinational from rf_addr)
//  cpu_stall      out  1   stall request to CPU
//  rf_addr        out  5   register file address
//  rf_wdata       out  32  register file write data
//  rf_we          out  1   register file write enable
//  pc_load        out  1   one-cycle strobe: CPU loads pc_out
//  pc_out         out  32  PC of incoming process
//  mem_base       out  32  base address of running process
//  pid_running    out  32  PID currently owning the CPU
//  busy           out  1   1 in every state except IDLE
//  switch_done    out  1   one-cycle pulse at end of switch
//  bad_pid        out  1   one-cycle pulse: request rejected, processo_atual >= NPROC
// BEHAVIOUR
//  Reset (async, mid-operation included): state=IDLE; all outputs 0; running_valid=0; all table valid bits cleared.
//  FSM: IDLE, STALL, SAVE_PC, SAVE_REGS, RESTORE_REGS, LOAD_PC, RELEASE.
//  IDLE: on troca_contexto=1, latch new_pid=processo_atual.
//   - new_pid >= NPROC: bad_pid=1 next cycle; stay IDLE.
//   - new_pid == pid_running and running_valid: switch_done=1 next cycle; no stall; stay IDLE.
//   - otherwise go STALL.
//   troca_contexto in any non-IDLE state is ignored (dropped, not queued).
//  STALL: cpu_stall=1; wait until cpu_halted=1.
//   - running_valid=1: go SAVE_PC.
//   - running_valid=0 (first switch after reset): skip saving; go RESTORE_REGS.
//  SAVE_PC (1 cycle): pc_tab[pid_running] <= cpu_pc.
//  SAVE_REGS (NREG cycles, i=0..NREG-1): rf_addr=i, rf_we=0; reg_tab[pid_running][i] <= rf_rdata.
//   On exit: valid[pid_running] <= 1.
//  RESTORE_REGS (NREG cycles, i=0..NREG-1): rf_addr=i, rf_we=1.
//   rf_wdata = reg_tab[new_pid][i] if valid[new_pid], else 0.
//  LOAD_PC (1 cycle): pc_load=1.
//   pc_out = pc_tab[new_pid] if valid[new_pid], else new_pid*PROC_SIZE (low 32 bits).
//   Same edge: mem_base <= new_pid*PROC_SIZE; pid_running <= new_pid; running_valid <= 1.
//  RELEASE (1 cycle): cpu_stall=0; switch_done=1; next state IDLE.
//  cpu_stall=1 in STALL through LOAD_PC inclusive. pc_out and mem_base hold their value until the next LOAD_PC.
//  Latency from the cycle cpu_halted is seen:
//   - running_valid=1: 2*NREG+3 cycles to switch_done (SAVE_PC, SAVE_REGS, RESTORE_REGS, LOAD_PC, RELEASE).
//   - first switch: NREG+2 cycles.
//  rf_addr and rf_we are 0 outside SAVE_REGS/RESTORE_REGS. Register counter wraps to 0 on state exit.
//  cpu_halted dropping during SAVE/RESTORE is ignored; the CPU must hold the halt while cpu_stall=1.
// TESTING
//  1. Reset, then troca_contexto with PID 2, cpu_halted=1 -> no save; rf writes 0 to regs 0..7;
//     pc_load with pc_out=2048; mem_base=2048; pid_running=2; switch_done after 10 cycles.
//  2. Running PID 2 with cpu_pc=0x850, regs=0x100+i; switch to PID 5, then back to 2 ->
//     restores regs 0x100+i and pc_out=0x850; total 19 cycles per switch.
//  3. troca_contexto with processo_atual=12 -> bad_pid pulse; cpu_stall stays 0; pid_running unchanged.
//  4. troca_contexto with PID equal to pid_running -> switch_done one cycle later; no cpu_stall, no rf_we.
//  5. Hold cpu_halted=0 for 7 cycles after stall -> FSM waits in STALL; no rf access until cpu_halted=1.
//     Second troca_contexto during busy is ignored.
//  6. Assert reset during RESTORE_REGS -> all outputs 0 immediately.
//     Next switch to any PID behaves as a first switch (fresh PC = pid*1024).

Source files
------------

// File: rtl/context_switcher.sv
// Context switch engine between the scheduler and the CPU core: stalls the CPU, saves the outgoing
// PC and registers into a per-PID table, restores the incoming context and reloads the PC.
module context_switcher #(
   parameter int unsigned NPROC     = 10,
   parameter int unsigned NREG      = 8,
   parameter logic [31:0] PROC_SIZE = 32'd1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        troca_contexto,
   input  logic [31:0] processo_atual,
   input  logic        cpu_halted,
   input  logic [31:0] cpu_pc,
   input  logic [31:0] rf_rdata,
   output logic        cpu_stall,
   output logic [4:0]  rf_addr,
   output logic [31:0] rf_wdata,
   output logic        rf_we,
   output logic        pc_load,
   output logic [31:0] pc_out,
   output logic [31:0] mem_base,
   output logic [31:0] pid_running,
   output logic        busy,
   output logic        switch_done,
   output logic        bad_pid
);

   localparam int unsigned PW = (NPROC > 1) ? $clog2(NPROC) : 1;
   localparam int unsigned RW = (NREG > 1) ? $clog2(NREG) : 1;

   typedef enum logic [2:0] {
      StIdle,
      StStall,
      StSavePc,
      StSaveRegs,
      StRestoreRegs,
      StLoadPc,
      StRelease
   } state_e;

   state_e            state_q;
   logic [PW-1:0]     new_pid_q;
   logic [PW-1:0]     pid_q;
   logic              running_valid_q;
   logic [NPROC-1:0]  valid_q;
   logic [4:0]        cnt_q;
   logic              cpu_stall_q;
   logic              rf_we_q;
   logic [31:0]       rf_wdata_q;
   logic              pc_load_q;
   logic [31:0]       pc_out_q;
   logic [31:0]       mem_base_q;
   logic              busy_q;
   logic              switch_done_q;
   logic              bad_pid_q;

   logic [31:0]       pc_tab  [NPROC];
   logic [31:0]       reg_tab [NPROC][NREG];

   logic              last_reg;
   logic [4:0]        cnt_inc;
   logic [31:0]       new_base;
   logic [31:0]       rd_first;
   logic [31:0]       rd_next;

   assign last_reg = (cnt_q == 5'(NREG - 1));
   assign cnt_inc  = cnt_q + 5'd1;
   assign new_base = 32'(new_pid_q) * PROC_SIZE;
   // A PID that was never saved restores as all-zero registers.
   assign rd_first = valid_q[new_pid_q] ? reg_tab[new_pid_q][{RW{1'b0}}] : 32'd0;
   assign rd_next  = valid_q[new_pid_q] ? reg_tab[new_pid_q][cnt_inc[RW-1:0]] : 32'd0;

   always_ff @(posedge clock) begin
      if (state_q == StSavePc) begin
         pc_tab[pid_q] <= cpu_pc;
      end
      if (state_q == StSaveRegs) begin
         reg_tab[pid_q][cnt_q[RW-1:0]] <= rf_rdata;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q         <= StIdle;
         new_pid_q       <= '0;
         pid_q           <= '0;
         running_valid_q <= 1'b0;
         valid_q         <= '0;
         cnt_q           <= '0;
         cpu_stall_q     <= 1'b0;
         rf_we_q         <= 1'b0;
         rf_wdata_q      <= '0;
         pc_load_q       <= 1'b0;
         pc_out_q        <= '0;
         mem_base_q      <= '0;
         busy_q          <= 1'b0;
         switch_done_q   <= 1'b0;
         bad_pid_q       <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               switch_done_q <= 1'b0;
               bad_pid_q     <= 1'b0;
               if (troca_contexto) begin
                  if (processo_atual >= 32'(NPROC)) begin
                     bad_pid_q <= 1'b1;
                  end else if (running_valid_q && processo_atual == 32'(pid_q)) begin
                     switch_done_q <= 1'b1;
                  end else begin
                     new_pid_q   <= processo_atual[PW-1:0];
                     cpu_stall_q <= 1'b1;
                     busy_q      <= 1'b1;
                     state_q     <= StStall;
                  end
               end
            end
            StStall: begin
               if (cpu_halted) begin
                  if (running_valid_q) begin
                     state_q <= StSavePc;
                  end else begin
                     rf_we_q    <= 1'b1;
                     rf_wdata_q <= rd_first;
                     state_q    <= StRestoreRegs;
                  end
               end
            end
            StSavePc: begin
               state_q <= StSaveRegs;
            end
            StSaveRegs: begin
               if (last_reg) begin
                  cnt_q          <= '0;
                  valid_q[pid_q] <= 1'b1;
                  rf_we_q        <= 1'b1;
                  rf_wdata_q     <= rd_first;
                  state_q        <= StRestoreRegs;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            StRestoreRegs: begin
               if (last_reg) begin
                  cnt_q           <= '0;
                  rf_we_q         <= 1'b0;
                  rf_wdata_q      <= '0;
                  pc_load_q       <= 1'b1;
                  pc_out_q        <= valid_q[new_pid_q] ? pc_tab[new_pid_q] : new_base;
                  mem_base_q      <= new_base;
                  pid_q           <= new_pid_q;
                  running_valid_q <= 1'b1;
                  state_q         <= StLoadPc;
               end else begin
                  cnt_q      <= cnt_inc;
                  rf_wdata_q <= rd_next;
               end
            end
            StLoadPc: begin
               pc_load_q     <= 1'b0;
               cpu_stall_q   <= 1'b0;
               switch_done_q <= 1'b1;
               state_q       <= StRelease;
            end
            StRelease: begin
               switch_done_q <= 1'b0;
               busy_q        <= 1'b0;
               state_q       <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // The counter idles at zero, so it doubles as the register file address.
   assign rf_addr     = cnt_q;
   assign cpu_stall   = cpu_stall_q;
   assign rf_we       = rf_we_q;
   assign rf_wdata    = rf_wdata_q;
   assign pc_load     = pc_load_q;
   assign pc_out      = pc_out_q;
   assign mem_base    = mem_base_q;
   assign pid_running = 32'(pid_q);
   assign busy        = busy_q;
   assign switch_done = switch_done_q;
   assign bad_pid     = bad_pid_q;

endmodule

// File: tb/tb_context_switcher.sv
// Directed bench for context_switcher with a behavioural register file and activity monitors.
module tb_context_switcher;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        troca_contexto = 1'b0;
   logic [31:0] processo_atual = '0;
   logic        cpu_halted = 1'b0;
   logic [31:0] cpu_pc = '0;
   logic [31:0] rf_rdata;
   logic        cpu_stall;
   logic [4:0]  rf_addr;
   logic [31:0] rf_wdata;
   logic        rf_we;
   logic        pc_load;
   logic [31:0] pc_out;
   logic [31:0] mem_base;
   logic [31:0] pid_running;
   logic        busy;
   logic        switch_done;
   logic        bad_pid;

   context_switcher dut (
      .clock          (clock),
      .reset          (reset),
      .troca_contexto (troca_contexto),
      .processo_atual (processo_atual),
      .cpu_halted     (cpu_halted),
      .cpu_pc         (cpu_pc),
      .rf_rdata       (rf_rdata),
      .cpu_stall      (cpu_stall),
      .rf_addr        (rf_addr),
      .rf_wdata       (rf_wdata),
      .rf_we          (rf_we),
      .pc_load        (pc_load),
      .pc_out         (pc_out),
      .mem_base       (mem_base),
      .pid_running    (pid_running),
      .busy           (busy),
      .switch_done    (switch_done),
      .bad_pid        (bad_pid)
   );

   always #5 clock = ~clock;

   logic [31:0] rf [32];
   logic        fill = 1'b0;
   logic [31:0] fill_base = '0;
   logic        clr = 1'b0;
   int          we_cnt = 0;
   int          ld_cnt = 0;
   int          stall_cnt = 0;
   logic [31:0] ld_pc = '0;

   int n_checks = 0;
   int n_fail = 0;

   assign rf_rdata = rf[rf_addr];

   always @(posedge clock) begin
      if (rf_we) begin
         rf[rf_addr] <= rf_wdata;
      end else if (fill) begin
         for (int i = 0; i < 32; i++) rf[i] <= fill_base + 32'(i);
      end
      if (clr) begin
         we_cnt    <= 0;
         ld_cnt    <= 0;
         stall_cnt <= 0;
      end else begin
         if (rf_we) we_cnt <= we_cnt + 1;
         if (cpu_stall) stall_cnt <= stall_cnt + 1;
         if (pc_load) begin
            ld_cnt <= ld_cnt + 1;
            ld_pc  <= pc_out;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic fill_rf(input logic [31:0] base);
      @(posedge clock); #1;
      fill = 1'b1; fill_base = base;
      @(posedge clock); #1;
      fill = 1'b0;
   endtask

   task automatic clear_mon();
      @(posedge clock); #1;
      clr = 1'b1;
      @(posedge clock); #1;
      clr = 1'b0;
   endtask

   // lat counts edges from raising cpu_halted until switch_done is seen.
   task automatic run_switch(input logic [31:0] pid, input int hold, input bit inject,
                             output int lat);
      @(posedge clock); #1;
      troca_contexto = 1'b1; processo_atual = pid; cpu_halted = 1'b0;
      @(posedge clock); #1;
      troca_contexto = 1'b0; processo_atual = '0;
      for (int i = 0; i < hold; i++) begin
         if (inject && i == 2) begin
            troca_contexto = 1'b1; processo_atual = 32'd7;
         end else begin
            troca_contexto = 1'b0;
         end
         @(posedge clock); #1;
      end
      troca_contexto = 1'b0;
      if (hold > 0) begin
         check("wait_no_rf", 32'(we_cnt), 32'd0);
         check("wait_stall", {31'd0, cpu_stall}, 32'd1);
         check("wait_rf_addr", {27'd0, rf_addr}, 32'd0);
      end
      cpu_halted = 1'b1;
      lat = 0;
      while (!switch_done && lat < 200) begin
         @(posedge clock); #1;
         lat++;
      end
      cpu_halted = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat;

      #3;
      check("rst_ctrl", {21'd0, cpu_stall, rf_we, pc_load, busy, switch_done, bad_pid, rf_addr},
            32'd0);
      check("rst_pid", pid_running, 32'd0);
      check("rst_pc_out", pc_out, 32'd0);
      check("rst_mem_base", mem_base, 32'd0);
      #9 reset = 1'b0;

      // First switch after reset: nothing saved, fresh PC.
      fill_rf(32'hdead_0000);
      clear_mon();
      run_switch(32'd2, 0, 1'b0, lat);
      check("t1_latency", 32'(lat), 32'd10);
      check("t1_stall_released", {31'd0, cpu_stall}, 32'd0);
      check("t1_rf_writes", 32'(we_cnt), 32'd8);
      check("t1_pc_loads", 32'(ld_cnt), 32'd1);
      check("t1_pc_out", ld_pc, 32'd2048);
      check("t1_mem_base", mem_base, 32'd2048);
      check("t1_pid", pid_running, 32'd2);
      for (int i = 0; i < 8; i++) check($sformatf("t1_rf%0d", i), rf[i], 32'd0);
      @(posedge clock); #1;
      check("t1_idle", {30'd0, busy, switch_done}, 32'd0);

      // 2 -> 5 (fresh) then 5 -> 2 (restored).
      fill_rf(32'h100);
      cpu_pc = 32'h850;
      clear_mon();
      run_switch(32'd5, 0, 1'b0, lat);
      check("t2a_latency", 32'(lat), 32'd19);
      check("t2a_pc_out", ld_pc, 32'd5120);
      check("t2a_mem_base", mem_base, 32'd5120);
      check("t2a_rf3", rf[3], 32'd0);
      check("t2a_stall_cycles", 32'(stall_cnt), 32'd19);
      fill_rf(32'h500);
      cpu_pc = 32'h1234;
      clear_mon();
      run_switch(32'd2, 0, 1'b0, lat);
      check("t2b_latency", 32'(lat), 32'd19);
      check("t2b_pc_out", ld_pc, 32'h850);
      check("t2b_mem_base", mem_base, 32'd2048);
      check("t2b_pid", pid_running, 32'd2);
      for (int i = 0; i < 8; i++) check($sformatf("t2b_rf%0d", i), rf[i], 32'h100 + 32'(i));

      // Out-of-range PID is rejected.
      clear_mon();
      @(posedge clock); #1;
      troca_contexto = 1'b1; processo_atual = 32'd12;
      @(posedge clock); #1;
      troca_contexto = 1'b0;
      check("t3_bad_pid", {31'd0, bad_pid}, 32'd1);
      check("t3_no_stall", {30'd0, cpu_stall, busy}, 32'd0);
      @(posedge clock); #1;
      check("t3_pulse_end", {31'd0, bad_pid}, 32'd0);
      check("t3_pid", pid_running, 32'd2);

      // Switching to the running PID completes immediately.
      @(posedge clock); #1;
      troca_contexto = 1'b1; processo_atual = 32'd2;
      @(posedge clock); #1;
      troca_contexto = 1'b0;
      check("t4_done", {31'd0, switch_done}, 32'd1);
      check("t4_no_stall", {30'd0, cpu_stall, busy}, 32'd0);
      @(posedge clock); #1;
      check("t4_pulse_end", {31'd0, switch_done}, 32'd0);
      check("t4_activity", 32'(we_cnt + stall_cnt), 32'd0);

      // Delayed halt with a dropped request while busy.
      clear_mon();
      run_switch(32'd3, 7, 1'b1, lat);
      check("t5_latency", 32'(lat), 32'd19);
      check("t5_pid", pid_running, 32'd3);
      check("t5_pc_out", ld_pc, 32'd3072);
      repeat (3) @(posedge clock);
      #1;
      check("t5_pc_loads", 32'(ld_cnt), 32'd1);
      check("t5_final", {busy, pid_running[30:0]}, 32'd3);

      // Reset in the middle of restoring PID 5.
      @(posedge clock); #1;
      troca_contexto = 1'b1; processo_atual = 32'd5;
      @(posedge clock); #1;
      troca_contexto = 1'b0; cpu_halted = 1'b1;
      repeat (12) @(posedge clock);
      #1;
      check("t6_restore_addr", {27'd0, rf_addr}, 32'd2);
      check("t6_restore_data", rf_wdata, 32'h502);
      check("t6_restore_we", {31'd0, rf_we}, 32'd1);
      #2 reset = 1'b1;
      #1;
      check("t6_rst_ctrl", {21'd0, cpu_stall, rf_we, pc_load, busy, switch_done, bad_pid, rf_addr},
            32'd0);
      check("t6_rst_data", rf_wdata | pc_out | mem_base | pid_running, 32'd0);
      #2 reset = 1'b0;
      cpu_halted = 1'b0;
      fill_rf(32'h900);
      clear_mon();
      run_switch(32'd5, 0, 1'b0, lat);
      check("t6_latency", 32'(lat), 32'd10);
      check("t6_pc_out", ld_pc, 32'd5120);
      check("t6_pid", pid_running, 32'd5);
      check("t6_rf_writes", 32'(we_cnt), 32'd8);
      for (int i = 0; i < 8; i++) check($sformatf("t6_rf%0d", i), rf[i], 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
